// File: rtl/tone_sequencer.sv
// Plays a fixed 8-note scale as (sound_on, half_period) for the piezo stage, with a silent gap after each note and optional looping.
// Outputs are registered and appear one cycle after start; there is no backpressure, stop aborts at once and start is ignored while busy.
module tone_sequencer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int NOTE_MS = 200,
    parameter int GAP_MS  = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic        busy,
    output logic        sound_on,
    output logic [25:0] half_period,
    output logic [2:0]  note_idx,
    output logic        done
);

    // 64-bit intermediate: NOTE_MS*CLK_HZ overflows 32 bits at the defaults
    localparam longint NOTE_CYC_L = (longint'(NOTE_MS) * longint'(CLK_HZ)) / 64'sd1000;
    localparam longint GAP_CYC_L  = (longint'(GAP_MS) * longint'(CLK_HZ)) / 64'sd1000;
    localparam int     NOTE_CYC   = int'(NOTE_CYC_L);
    localparam int     GAP_CYC    = int'(GAP_CYC_L);
    localparam int     MAX_CYC    = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
    localparam int     CW         = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam bit     HAS_GAP    = (GAP_CYC > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          seg_end;
    logic          last_note;

    function automatic logic [25:0] note_rom(input logic [2:0] idx);
        logic [25:0] hp;
        case (idx)
            3'd0:    hp = 26'd190840;
            3'd1:    hp = 26'd170068;
            3'd2:    hp = 26'd151515;
            3'd3:    hp = 26'd143266;
            3'd4:    hp = 26'd127551;
            3'd5:    hp = 26'd113636;
            3'd6:    hp = 26'd101214;
            default: hp = 26'd95602;
        endcase
        return hp;
    endfunction

    always_comb begin
        seg_end   = ((state == NOTE) && (cnt == NOTE_LAST)) ||
                    ((state == GAP)  && (cnt == GAP_LAST));
        last_note = (note_idx == 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            sound_on    <= 1'b0;
            half_period <= '0;
            note_idx    <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                cnt      <= '0;
                busy     <= 1'b0;
                sound_on <= 1'b0;
            end else if (state == IDLE) begin
                if (start) begin
                    state       <= NOTE;
                    cnt         <= '0;
                    busy        <= 1'b1;
                    sound_on    <= 1'b1;
                    note_idx    <= 3'd0;
                    half_period <= note_rom(3'd0);
                end
            end else if (seg_end) begin
                cnt <= '0;
                if ((state == NOTE) && HAS_GAP) begin
                    state    <= GAP;
                    sound_on <= 1'b0;
                end else if (!last_note) begin
                    state       <= NOTE;
                    sound_on    <= 1'b1;
                    note_idx    <= note_idx + 3'd1;
                    half_period <= note_rom(note_idx + 3'd1);
                end else if (loop_en) begin
                    state       <= NOTE;
                    sound_on    <= 1'b1;
                    note_idx    <= 3'd0;
                    half_period <= note_rom(3'd0);
                end else begin
                    // end of a non-looping pass: half_period and note_idx hold
                    state    <= IDLE;
                    busy     <= 1'b0;
                    sound_on <= 1'b0;
                    done     <= 1'b1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
